// File: rtl/sd_cmd_issue_ctrl.sv
// sd_cmd_issue_ctrl: sequences one SD command from the host command/argument registers to the CMD-line PHY.
// Latency: phy_req rises 1 cycle after cmd_wr_en. cmd_complete pulses 1 cycle after the last response or busy event.
// Backpressure: the PHY stalls the issue by withholding phy_ack. New writes while busy are dropped and flagged on wrReject.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   cmd_wr_en ..        host command-register write plus the fields latched with it
//   cmd_arg             command argument
//   abort, err_clr      host abort request and sticky-error clear
//   phy_*               request/ack handshake and response capture with the CMD-line PHY
//   busy_in             DAT0 busy level (1 = card busy)
//   cmd_inhibit ..      status back to the register set
//   resp_reg            last captured response
module sd_cmd_issue_ctrl #(
   parameter int RESP_TIMEOUT = 64,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_wr_en,
   input  logic [5:0]  cmd_index,
   input  logic [1:0]  cmd_type,
   input  logic        data_present,
   input  logic        idx_chk_en,
   input  logic        crc_chk_en,
   input  logic [1:0]  resp_type,
   input  logic [31:0] cmd_arg,
   input  logic        abort,
   input  logic        err_clr,
   output logic        phy_req,
   input  logic        phy_ack,
   output logic [37:0] phy_cmd,
   output logic        phy_long_resp,
   output logic [1:0]  phy_cmd_type,
   output logic        phy_data_present,
   input  logic        phy_resp_valid,
   input  logic [5:0]  phy_resp_index,
   input  logic        phy_resp_crc_ok,
   input  logic [31:0] phy_resp_data,
   input  logic        busy_in,
   output logic        cmd_inhibit,
   output logic        cmd_complete,
   output logic        wr_reject,
   output logic        err_timeout,
   output logic        err_crc,
   output logic        err_index,
   output logic [31:0] resp_reg
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, WAIT_BUSY, DONE} state_t;

   localparam logic [7:0] RESP_LAST = 8'(RESP_TIMEOUT - 1);
   localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [5:0]  idxQ;
   logic [31:0] argQ;
   logic [1:0]  typeQ;
   logic        dataPresentQ;
   logic        idxChkQ;
   logic        crcChkQ;
   logic [1:0]  respTypeQ;
   logic        phyReqQ;
   logic        inhibitQ;
   logic        completeQ;
   logic        rejectQ;
   logic        errTimeoutQ;
   logic        errCrcQ;
   logic        errIndexQ;
   logic [31:0] respQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         idxQ         <= '0;
         argQ         <= '0;
         typeQ        <= '0;
         dataPresentQ <= 1'b0;
         idxChkQ      <= 1'b0;
         crcChkQ      <= 1'b0;
         respTypeQ    <= '0;
         phyReqQ      <= 1'b0;
         inhibitQ     <= 1'b0;
         completeQ    <= 1'b0;
         rejectQ      <= 1'b0;
         errTimeoutQ  <= 1'b0;
         errCrcQ      <= 1'b0;
         errIndexQ    <= 1'b0;
         respQ        <= '0;
      end else begin
         completeQ <= 1'b0;
         // Any write outside IDLE (DONE included) is dropped; latches are untouched.
         rejectQ   <= cmd_wr_en && (state != IDLE);

         // Clear first so that a set further down in the same cycle wins.
         if (err_clr) begin
            errTimeoutQ <= 1'b0;
            errCrcQ     <= 1'b0;
            errIndexQ   <= 1'b0;
         end

         if (abort && (state != IDLE)) begin
            // Abort overrides everything: no completion, response and flags untouched.
            state    <= IDLE;
            phyReqQ  <= 1'b0;
            inhibitQ <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_wr_en) begin
                     idxQ         <= cmd_index;
                     argQ         <= cmd_arg;
                     typeQ        <= cmd_type;
                     dataPresentQ <= data_present;
                     idxChkQ      <= idx_chk_en;
                     crcChkQ      <= crc_chk_en;
                     respTypeQ    <= resp_type;
                     phyReqQ      <= 1'b1;
                     inhibitQ     <= 1'b1;
                     state        <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (phy_ack) begin
                     phyReqQ <= 1'b0;
                     cnt     <= '0;
                     if (respTypeQ == 2'b00) begin
                        state     <= DONE;
                        completeQ <= 1'b1;
                     end else begin
                        state <= WAIT_RESP;
                     end
                  end
               end
               WAIT_RESP: begin
                  cnt <= cnt + 8'd1;
                  // A response on the final count still counts as on time.
                  if (phy_resp_valid) begin
                     respQ <= phy_resp_data;
                     if (crcChkQ && !phy_resp_crc_ok)
                        errCrcQ <= 1'b1;
                     if (idxChkQ && (phy_resp_index != idxQ))
                        errIndexQ <= 1'b1;
                     if (respTypeQ == 2'b11) begin
                        cnt   <= '0;
                        state <= WAIT_BUSY;
                     end else begin
                        state     <= DONE;
                        completeQ <= 1'b1;
                     end
                  end else if (cnt == RESP_LAST) begin
                     errTimeoutQ <= 1'b1;
                     state       <= DONE;
                     completeQ   <= 1'b1;
                  end
               end
               WAIT_BUSY: begin
                  cnt <= cnt + 8'd1;
                  if (!busy_in) begin
                     state     <= DONE;
                     completeQ <= 1'b1;
                  end else if (cnt == BUSY_LAST) begin
                     errTimeoutQ <= 1'b1;
                     state       <= DONE;
                     completeQ   <= 1'b1;
                  end
               end
               DONE: begin
                  state    <= IDLE;
                  inhibitQ <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  phyReqQ  <= 1'b0;
                  inhibitQ <= 1'b0;
               end
            endcase
         end
      end
   end

   assign phy_req          = phyReqQ;
   assign phy_cmd          = {idxQ, argQ};
   assign phy_long_resp    = (respTypeQ == 2'b01);
   assign phy_cmd_type     = typeQ;
   assign phy_data_present = dataPresentQ;
   assign cmd_inhibit      = inhibitQ;
   assign cmd_complete     = completeQ;
   assign wr_reject        = rejectQ;
   assign err_timeout      = errTimeoutQ;
   assign err_crc          = errCrcQ;
   assign err_index        = errIndexQ;
   assign resp_reg         = respQ;

endmodule
